// File: rtl/fixed_divider_pkg.sv
// Shared widths, state encoding and saturation constant for the fixed-point divider.
package fixed_divider_pkg;

    localparam int unsigned FP_INT_W  = 32;
    localparam int unsigned FP_FRAC_W = 23;

    localparam logic [127:0] FP_SAT_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/fixed_divider_restoring_step.sv
// One radix-2 restoring division step: shift in a numerator bit, conditionally subtract.
module div_restoring_step #(
    parameter int unsigned W = 55
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W:0]   rem_o,
    output logic         q_bit_o
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - (W+2)'(div_i);
        q_bit_o = (shifted >= (W+2)'(div_i));
        // Remainder stays below the divisor, so the top bit is always zero here.
        rem_o   = q_bit_o ? (W+1)'(diff) : (W+1)'(shifted);
    end

endmodule

// File: rtl/fixed_divider.sv
// Sequential unsigned fixed-point divider, one quotient bit per clock, valid/ready on both sides.
module fixed_divider
    import fixed_divider_pkg::*;
#(
    parameter int unsigned num_of_int  = FP_INT_W,
    parameter int unsigned num_of_frac = FP_FRAC_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [num_of_int-1:0]  IN_INT_1,
    input  logic [num_of_frac-1:0] IN_FRAC_1,
    input  logic [num_of_int-1:0]  IN_INT_2,
    input  logic [num_of_frac-1:0] IN_FRAC_2,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [num_of_int-1:0]  OUT_INT,
    output logic [num_of_frac-1:0] OUT_FRAC,
    output logic                   DIV_ZERO,
    output logic                   OVERFLOW
);

    localparam int unsigned W     = num_of_int + num_of_frac;
    localparam int unsigned N     = W + num_of_frac;
    localparam int unsigned CNT_W = $clog2(N);

    div_state_t state_q, state_d;

    logic [N-1:0]           num_q;
    logic [W-1:0]           div_q;
    logic [W:0]             rem_q;
    logic [N-1:0]           quo_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [num_of_int-1:0]  out_int_q;
    logic [num_of_frac-1:0] out_frac_q;
    logic                   div_zero_q;
    logic                   overflow_q;

    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         b_zero;
    logic [W:0]   rem_next;
    logic         q_bit;
    logic [N-1:0] q_next;

    assign a_in   = {IN_INT_1, IN_FRAC_1};
    assign b_in   = {IN_INT_2, IN_FRAC_2};
    assign b_zero = (b_in == '0);
    assign q_next = (quo_q << 1) | N'(q_bit);

    div_restoring_step #(.W(W)) u_step (
        .rem_i   (rem_q),
        .bit_i   (num_q[N-1]),
        .div_i   (div_q),
        .rem_o   (rem_next),
        .q_bit_o (q_bit)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (IN_VALID) state_d = b_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (OUT_READY) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        unique case (state_q)
            ST_IDLE: IN_READY  = 1'b1;
            ST_DONE: OUT_VALID = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch, restoring iteration, result and flag registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            num_q      <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            out_int_q  <= '0;
            out_frac_q <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        if (b_zero) begin
                            div_zero_q <= 1'b1;
                            overflow_q <= 1'b0;
                            out_int_q  <= FP_SAT_ONES[num_of_int-1:0];
                            out_frac_q <= FP_SAT_ONES[num_of_frac-1:0];
                        end else begin
                            num_q <= {a_in, num_of_frac'(0)};
                            div_q <= b_in;
                            rem_q <= '0;
                            quo_q <= '0;
                            cnt_q <= CNT_W'(N - 1);
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_next;
                    num_q <= num_q << 1;
                    quo_q <= q_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        // Any quotient bit above W cannot be represented: saturate.
                        if (|q_next[N-1:W]) begin
                            overflow_q <= 1'b1;
                            out_int_q  <= FP_SAT_ONES[num_of_int-1:0];
                            out_frac_q <= FP_SAT_ONES[num_of_frac-1:0];
                        end else begin
                            overflow_q <= 1'b0;
                            out_int_q  <= q_next[W-1:num_of_frac];
                            out_frac_q <= q_next[num_of_frac-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        div_zero_q <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign OUT_INT  = out_int_q;
    assign OUT_FRAC = out_frac_q;
    assign DIV_ZERO = div_zero_q;
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Directed self-checking bench for fixed_divider with hand-computed quotients.
module tb_fixed_divider;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_INT_1;
    logic [22:0] IN_FRAC_1;
    logic [31:0] IN_INT_2;
    logic [22:0] IN_FRAC_2;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_INT;
    logic [22:0] OUT_FRAC;
    logic        DIV_ZERO;
    logic        OVERFLOW;

    int total = 0;
    int bad   = 0;
    int lat;
    int seen;

    fixed_divider #(.num_of_int(32), .num_of_frac(23)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_INT_1  (IN_INT_1),
        .IN_FRAC_1 (IN_FRAC_1),
        .IN_INT_2  (IN_INT_2),
        .IN_FRAC_2 (IN_FRAC_2),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_INT   (OUT_INT),
        .OUT_FRAC  (OUT_FRAC),
        .DIV_ZERO  (DIV_ZERO),
        .OVERFLOW  (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lat = edges after the acceptance edge until OUT_VALID is seen (0 = valid right after it)
    task automatic run_op(input logic [31:0] ai, input logic [22:0] af,
                          input logic [31:0] bi, input logic [22:0] bf,
                          output int latency);
        @(negedge CLK);
        IN_INT_1 = ai; IN_FRAC_1 = af; IN_INT_2 = bi; IN_FRAC_2 = bf;
        IN_VALID = 1'b1;
        check("in_ready_before_accept", 64'(IN_READY), 64'd1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        latency = 0;
        while (!OUT_VALID && latency < 200) begin
            if (latency == 10) begin
                IN_INT_1 = $urandom; IN_INT_2 = $urandom; IN_FRAC_2 = 23'($urandom);
            end
            @(posedge CLK); #1;
            latency++;
        end
    endtask

    task automatic consume();
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("consume_out_valid", 64'(OUT_VALID), 64'd0);
        check("consume_in_ready", 64'(IN_READY), 64'd1);
        check("consume_flags", 64'({DIV_ZERO, OVERFLOW}), 64'd0);
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_INT_1 = '0; IN_FRAC_1 = '0; IN_INT_2 = '0; IN_FRAC_2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_outputs", 64'({OUT_INT, OUT_FRAC}), 64'd0);
        check("rst_flags", 64'({DIV_ZERO, OVERFLOW}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // 6.0 / 2.0 = 3.0, N=78 edges
        run_op(32'd6, 23'd0, 32'd2, 23'd0, lat);
        check("6div2_latency", 64'(lat), 64'd78);
        check("6div2_int", 64'(OUT_INT), 64'd3);
        check("6div2_frac", 64'(OUT_FRAC), 64'd0);
        check("6div2_flags", 64'({DIV_ZERO, OVERFLOW}), 64'd0);
        check("6div2_in_ready_busy", 64'(IN_READY), 64'd0);
        consume();

        // 1.0 / 3.0 truncated: floor(2^23/3) = 0x2AAAAA
        run_op(32'd1, 23'd0, 32'd3, 23'd0, lat);
        check("1div3_latency", 64'(lat), 64'd78);
        check("1div3_int", 64'(OUT_INT), 64'd0);
        check("1div3_frac", 64'(OUT_FRAC), 64'h2AAAAA);
        check("1div3_flags", 64'({DIV_ZERO, OVERFLOW}), 64'd0);
        consume();

        // 7.5 / 0.5 = 15.0, then hold OUT_READY low for 10 cycles
        run_op(32'd7, 23'h400000, 32'd0, 23'h400000, lat);
        check("7p5div0p5_int", 64'(OUT_INT), 64'd15);
        check("7p5div0p5_frac", 64'(OUT_FRAC), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("stall_out_valid", 64'(OUT_VALID), 64'd1);
            check("stall_in_ready", 64'(IN_READY), 64'd0);
            check("stall_int", 64'(OUT_INT), 64'd15);
        end
        consume();

        // 5.0 / 0: immediate DIV_ZERO with saturated outputs
        run_op(32'd5, 23'd0, 32'd0, 23'd0, lat);
        check("div0_latency", 64'(lat), 64'd0);
        check("div0_flag", 64'(DIV_ZERO), 64'd1);
        check("div0_ovf", 64'(OVERFLOW), 64'd0);
        check("div0_int", 64'(OUT_INT), 64'hFFFFFFFF);
        check("div0_frac", 64'(OUT_FRAC), 64'h7FFFFF);
        consume();

        // 2^31 / 0.25 = 2^33 does not fit: OVERFLOW and saturation
        run_op(32'h80000000, 23'd0, 32'd0, 23'h200000, lat);
        check("ovf_latency", 64'(lat), 64'd78);
        check("ovf_flag", 64'(OVERFLOW), 64'd1);
        check("ovf_divzero", 64'(DIV_ZERO), 64'd0);
        check("ovf_int", 64'(OUT_INT), 64'hFFFFFFFF);
        check("ovf_frac", 64'(OUT_FRAC), 64'h7FFFFF);
        consume();

        // 0 / 3.0 = 0 with no flags
        run_op(32'd0, 23'd0, 32'd3, 23'd0, lat);
        check("zero_num_out", 64'({OUT_INT, OUT_FRAC}), 64'd0);
        check("zero_num_flags", 64'({DIV_ZERO, OVERFLOW}), 64'd0);
        consume();

        // Reset 20 edges into CALC aborts the operation
        @(negedge CLK);
        IN_INT_1 = 32'd9; IN_FRAC_1 = '0; IN_INT_2 = 32'd4; IN_FRAC_2 = '0;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        check("precut_in_ready", 64'(IN_READY), 64'd0);
        RST = 1'b1;
        #1;
        check("abort_in_ready", 64'(IN_READY), 64'd1);
        check("abort_out_valid", 64'(OUT_VALID), 64'd0);
        check("abort_outputs", 64'({OUT_INT, OUT_FRAC}), 64'd0);
        check("abort_flags", 64'({DIV_ZERO, OVERFLOW}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);

        run_op(32'd6, 23'd0, 32'd2, 23'd0, lat);
        check("post_rst_latency", 64'(lat), 64'd78);
        check("post_rst_int", 64'(OUT_INT), 64'd3);
        check("post_rst_frac", 64'(OUT_FRAC), 64'd0);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixed_divider.md
Name: fixed_divider

Overview:
- Sequential unsigned fixed-point divider; inverse operation of the team's fixed-point multiplier.
- Uses the same split integer/fraction operand format, so quotients feed directly back into the exponential datapath (e.g. normalisation, 1/x terms).
- Radix-2 restoring division, one quotient bit per clock.
- Valid/ready handshake on the input side and on the output side.

Parameters:
- num_of_int, 32, integer-part width of operands and result.
- num_of_frac, 23, fraction-part width of operands and result.
- Derived (localparam): W = num_of_int + num_of_frac (operand width); N = W + num_of_frac (numerator and quotient width, 78 by default).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operands present.
- IN_READY  out  1  divider can accept operands (high only in IDLE).
- IN_INT_1  in  num_of_int  dividend integer part.
- IN_FRAC_1  in  num_of_frac  dividend fraction part.
- IN_INT_2  in  num_of_int  divisor integer part.
- IN_FRAC_2  in  num_of_frac  divisor fraction part.
- OUT_VALID  out  1  result valid; held until consumed.
- OUT_READY  in  1  consumer accepts the result.
- OUT_INT  out  num_of_int  quotient integer part.
- OUT_FRAC  out  num_of_frac  quotient fraction part.
- DIV_ZERO  out  1  divisor was zero; qualified by OUT_VALID.
- OVERFLOW  out  1  quotient exceeded W bits; qualified by OUT_VALID.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; IN_READY=1.
  - OUT_VALID, DIV_ZERO, OVERFLOW = 0; OUT_INT, OUT_FRAC = 0; all datapath registers cleared.
  - RST asserted mid-CALC or mid-DONE aborts the operation; no result is ever delivered for it.
- Arithmetic:
  - A = {IN_INT_1, IN_FRAC_1}, B = {IN_INT_2, IN_FRAC_2}, both W-bit unsigned.
  - Numerator = {A, num_of_frac zeros} (N bits); Q = floor(Numerator / B), N bits. Truncation; no rounding.
  - Result = Q[W-1:0]: OUT_INT = Q[W-1:num_of_frac], OUT_FRAC = Q[num_of_frac-1:0].
  - OVERFLOW = 1 when any bit of Q[N-1:W] is set; outputs then saturate to all ones.
- State machine: IDLE, CALC, DONE.
  - IDLE: IN_READY=1.
    - On an edge with IN_VALID=1 and B≠0: latch operands, clear partial remainder (W+1 bits), bit counter=N-1, go to CALC.
    - On an edge with IN_VALID=1 and B=0: go directly to DONE with DIV_ZERO=1 and OUT_INT/OUT_FRAC all ones (latency 1 edge).
  - CALC: IN_READY=0; each edge performs one restoring step:
    - Shift remainder left, bringing in the next numerator bit, MSB first.
    - If remainder ≥ B, subtract B and shift 1 into Q; otherwise shift 0.
    - Decrement the counter. On the edge where counter=0, go to DONE with the result and flags registered.
  - DONE: OUT_VALID=1; outputs and flags stable.
    - On an edge with OUT_READY=1, go to IDLE and clear OUT_VALID.
    - OUT_READY low stalls indefinitely with outputs held.
- Latency: OUT_VALID is visible after the N-th edge following the acceptance edge (78 for defaults). Divide-by-zero: after 1 edge.
- Throughput: one operation at a time. IN_READY rises only after the result is consumed, so a new operand can be accepted on the edge after the OUT_READY consumption edge.
- Operand changes while IN_READY=0 are ignored.
- DIV_ZERO and OVERFLOW are never both set. Flags clear when DONE exits.
- A divisor smaller than 1 (INT=0) is legal. Dividend 0 yields 0 with no flags.

Decomposition:
- Shared package:
  - default widths: FP_INT_W=32, FP_FRAC_W=23.
  - state encoding for IDLE/CALC/DONE.
  - the saturation constant (all ones).
- One natural sub-module: div_restoring_step. Combinational; takes the remainder, the next numerator bit and B; outputs the next remainder and the quotient bit.
  - fixed_divider instantiates it once and owns the FSM, counter and registers.

Test Plan:
- 6.0 / 2.0 (INT_1=6, FRAC_1=0, INT_2=2, FRAC_2=0) -> OUT_INT=3, OUT_FRAC=0, flags 0, OUT_VALID exactly 78 edges after acceptance.
- 1.0 / 3.0 -> OUT_INT=0, OUT_FRAC=0x2AAAAA (truncated), flags 0.
- 7.5 / 0.5 (FRAC_1=0x400000, INT_2=0, FRAC_2=0x400000) -> OUT_INT=15, OUT_FRAC=0.
- Divisor 0, dividend 5.0 -> OUT_VALID after 1 edge, DIV_ZERO=1, OUT_INT=0xFFFFFFFF, OUT_FRAC=0x7FFFFF.
- 2^31 / 0.25 (INT_1=0x80000000, INT_2=0, FRAC_2=0x200000) -> OVERFLOW=1, outputs all ones.
- Protocol cases:
  - RST pulsed 20 edges into CALC -> IN_READY=1 and all outputs 0 immediately; the next operation 6/2 completes correctly.
  - OUT_READY held low 10 cycles -> outputs held and IN_READY=0 throughout.
